regfile_sb: RTL and testbench

Parametrised multi-port CPU register file with an integrated write scoreboard. It is the next generation of the pipeline's 32x32 register file, which has two read ports, one write port, forwarding and a `$sp` reset value. This block makes width, depth and read/write port counts configurable, and it tracks the destinations of in-flight instructions so the issue stage can stall on read-after-write hazards. It sits between decode/issue, which reads operands and reserves destinations, and writeback, which commits results and releases destinations.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/rf_scoreboard.sv | 50 +++++
 rtl/regfile_sb.sv | 83 ++++++++
 tb/tb_regfile_sb.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, vector typedefs and the popcount helper for the
// scoreboarded register file.
package regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_SP_IDX = 29;
   localparam logic [31:0] DEF_SP_INIT = 32'h0000_07fc;

   // Widest pending vector popcount supports (ADDR_W up to 8).
   localparam int POP_W = 256;

   typedef logic [DEF_ADDR_W-1:0] addr_t;
   typedef logic [DEF_DATA_W-1:0] data_t;

   function automatic logic [8:0] popcount(input logic [POP_W-1:0] v);
      logic [8:0] c;
      c = '0;
      for (int i = 0; i < POP_W; i++) c = c + 9'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination tracker: issue sets, writeback clears, flush wipes all.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_WR = 2,
   localparam int DEPTH = 2**ADDR_W
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             iss,
   input  logic [ADDR_W-1:0]                iss_addr,
   input  logic [NUM_WR-1:0]                wr_en,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]    wr_addr,
   input  logic                             flush,
   output logic [DEPTH-1:0]                 pending,
   output logic [ADDR_W:0]                  pend_cnt
);

   localparam int CW = ADDR_W + 1;

   logic [DEPTH-1:0] pend_nxt;
   logic [POP_W-1:0] pend_ext;

   // Priority low to high: write clear, issue set (younger owner), flush.
   always_comb begin
      pend_nxt = pending;
      for (int j = 0; j < NUM_WR; j++)
         if (wr_en[j]) pend_nxt[wr_addr[j]] = 1'b0;
      if (iss) pend_nxt[iss_addr] = 1'b1;
      if (flush) pend_nxt = '0;
      pend_nxt[0] = 1'b0;
   end

   always_comb begin
      pend_ext = '0;
      pend_ext[DEPTH-1:0] = pend_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending  <= '0;
         pend_cnt <= '0;
      end else begin
         pending  <= pend_nxt;
         pend_cnt <= CW'(popcount(pend_ext));
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write bypass and RAW scoreboard gating
// of the read ports.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int          DATA_W  = DEF_DATA_W,
   parameter int          ADDR_W  = DEF_ADDR_W,
   parameter int          NUM_RD  = 2,
   parameter int          NUM_WR  = 2,
   parameter int          SP_IDX  = DEF_SP_IDX,
   parameter logic [31:0] SP_INIT = DEF_SP_INIT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic [NUM_WR-1:0]          wr_en,
   input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
   input  logic [NUM_WR*DATA_W-1:0]   wr_data,
   input  logic                       iss_en,
   input  logic [ADDR_W-1:0]          iss_addr,
   input  logic                       flush,
   output logic [ADDR_W:0]            pend_cnt
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_INIT);

   logic [NUM_RD-1:0][ADDR_W-1:0] ra_v;
   logic [NUM_RD-1:0][DATA_W-1:0] rd_v;
   logic [NUM_WR-1:0][ADDR_W-1:0] wa_v;
   logic [NUM_WR-1:0][DATA_W-1:0] wd_v;
   logic [DEPTH-1:0][DATA_W-1:0]  regs;
   logic [DEPTH-1:0]              pending;

   assign ra_v    = rd_addr;
   assign wa_v    = wr_addr;
   assign wd_v    = wr_data;
   assign rd_data = rd_v;

   // Register 0 is never written, so it holds its reset zero forever.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) regs[k] <= (k == SP_IDX) ? SP_RST : '0;
      end else begin
         for (int j = 0; j < NUM_WR; j++)
            if (wr_en[j] && wa_v[j] != '0) regs[wa_v[j]] <= wd_v[j];
      end
   end

   rf_scoreboard #(.ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_sb (
      .clk      (clk),
      .reset    (reset),
      .iss      (iss_en),
      .iss_addr (iss_addr),
      .wr_en    (wr_en),
      .wr_addr  (wa_v),
      .flush    (flush),
      .pending  (pending),
      .pend_cnt (pend_cnt)
   );

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic              hit;
      logic [DATA_W-1:0] byp;

      // Bypass is suppressed in reset so reads show the reset storage.
      always_comb begin
         hit = 1'b0;
         byp = '0;
         for (int j = 0; j < NUM_WR; j++)
            if (wr_en[j] && wa_v[j] == ra_v[i] && !reset) begin
               hit = 1'b1;
               byp = wd_v[j];
            end
      end

      assign rd_v[i]    = (ra_v[i] == '0) ? '0 : hit ? byp : regs[ra_v[i]];
      assign rd_busy[i] = pending[ra_v[i]] & ~hit;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector table, mid-cycle reset sequence and randomized traffic
// against an array-based reference model of the register file.
module tb_regfile_sb;
   import regfile_pkg::*;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0][4:0]  rd_a;
   logic [1:0][31:0] rd_d;
   logic [1:0]       rd_busy;
   logic [1:0]       wr_en;
   logic [1:0][4:0]  wr_a;
   logic [1:0][31:0] wr_d;
   logic             iss_en;
   logic [4:0]       iss_addr;
   logic             flush;
   logic [5:0]       pend_cnt;

   int n_chk = 0;
   int n_fail = 0;

   data_t m_reg [32];
   bit    m_pend[32];

   regfile_sb dut (
      .clk(clk), .reset(reset), .rd_addr(rd_a), .rd_data(rd_d), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_a), .wr_data(wr_d), .iss_en(iss_en),
      .iss_addr(iss_addr), .flush(flush), .pend_cnt(pend_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] ra0, ra1;
      logic [1:0] we;
      logic [4:0] wa0, wa1;
      logic [31:0] wd0, wd1;
      logic ie;
      logic [4:0] ia;
      logic fl;
      logic [31:0] ed0, ed1;
      logic [1:0] eb;
      logic [5:0] ec;
   } vec_t;

   vec_t vt[14];

   function automatic vec_t mk(input int ra0, ra1, we, wa0, wa1,
                               input logic [31:0] wd0, wd1,
                               input int ie, ia, fl,
                               input logic [31:0] ed0, ed1,
                               input int eb, ec);
      vec_t v;
      v.ra0 = 5'(ra0); v.ra1 = 5'(ra1); v.we = 2'(we);
      v.wa0 = 5'(wa0); v.wa1 = 5'(wa1); v.wd0 = wd0; v.wd1 = wd1;
      v.ie = 1'(ie); v.ia = 5'(ia); v.fl = 1'(fl);
      v.ed0 = ed0; v.ed1 = ed1; v.eb = 2'(eb); v.ec = 6'(ec);
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int a = 0; a < 32; a++) begin
         m_reg[a]  = (a == 29) ? 32'h7fc : 32'h0;
         m_pend[a] = 1'b0;
      end
   endtask

   // Expected read from the architectural rules: zero reg, last-port bypass, storage.
   task automatic m_read(input logic [4:0] a, output logic [31:0] d, output logic b);
      bit hit = 0;
      d = m_reg[a];
      for (int j = 0; j < 2; j++)
         if (wr_en[j] && wr_a[j] == a) begin hit = 1; d = wr_d[j]; end
      if (a == 0) d = 0;
      b = (a != 0) && m_pend[a] && !hit;
   endtask

   task automatic m_commit();
      data_t nr[32];
      bit    np[32];
      nr = m_reg;
      for (int j = 0; j < 2; j++)
         if (wr_en[j] && wr_a[j] != 0) nr[wr_a[j]] = wr_d[j];
      for (int a = 0; a < 32; a++) begin
         bit written = 0;
         for (int j = 0; j < 2; j++) if (wr_en[j] && wr_a[j] == a) written = 1;
         if (a == 0 || flush)              np[a] = 0;
         else if (iss_en && iss_addr == a) np[a] = 1;
         else if (written)                 np[a] = 0;
         else                              np[a] = m_pend[a];
      end
      m_reg  = nr;
      m_pend = np;
   endtask

   function automatic int m_count();
      int c = 0;
      for (int a = 0; a < 32; a++) c += int'(m_pend[a]);
      return c;
   endfunction

   task automatic model_comb(input string tag);
      logic [31:0] ed;
      logic        eb;
      for (int i = 0; i < 2; i++) begin
         m_read(rd_a[i], ed, eb);
         chk($sformatf("%s rd_data[%0d]", tag, i), rd_d[i], ed);
         chk($sformatf("%s rd_busy[%0d]", tag, i), rd_busy[i], eb);
      end
   endtask

   task automatic clock_commit(input string tag);
      @(posedge clk);
      m_commit();
      #1;
      chk({tag, " pend_cnt"}, pend_cnt, m_count());
   endtask

   task automatic idle();
      wr_en = 0; wr_a = '0; wr_d = '0; iss_en = 0; iss_addr = 0; flush = 0;
   endtask

   task automatic step(input string tag);
      #3;
      model_comb(tag);
      clock_commit(tag);
   endtask

   initial begin
      reset = 1'b1;
      rd_a = '0;
      idle();
      m_reset();

      vt[0]  = mk(29, 5, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7fc, 0, 0, 0);
      vt[1]  = mk(0, 7, 1, 7, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0);
      vt[2]  = mk(7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
      vt[3]  = mk(9, 0, 3, 9, 9, 1, 2, 0, 0, 0, 2, 0, 0, 0);
      vt[4]  = mk(9, 0, 1, 0, 0, 32'hFF, 0, 0, 0, 0, 2, 0, 0, 0);
      vt[5]  = mk(4, 4, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 1);
      vt[6]  = mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      vt[7]  = mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      vt[8]  = mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      vt[9]  = mk(4, 0, 1, 4, 0, 32'hAA, 0, 0, 0, 0, 32'hAA, 0, 0, 0);
      vt[10] = mk(4, 0, 0, 0, 0, 0, 0, 1, 3, 0, 32'hAA, 0, 0, 1);
      vt[11] = mk(3, 4, 2, 0, 3, 0, 32'h33, 1, 3, 0, 32'h33, 32'hAA, 0, 1);
      vt[12] = mk(3, 6, 0, 0, 0, 0, 0, 1, 6, 1, 32'h33, 0, 1, 0);
      vt[13] = mk(3, 6, 0, 0, 0, 0, 0, 0, 0, 0, 32'h33, 0, 0, 0);

      // Reset state is visible combinationally while reset is held.
      rd_a[0] = 29; rd_a[1] = 5;
      #12;
      chk("reset rd_data[0]", rd_d[0], 32'h7fc);
      chk("reset rd_data[1]", rd_d[1], 0);
      chk("reset rd_busy", rd_busy, 2'b00);
      chk("reset pend_cnt", pend_cnt, 0);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      for (int k = 0; k < 14; k++) begin
         rd_a[0] = vt[k].ra0; rd_a[1] = vt[k].ra1;
         wr_en = vt[k].we;
         wr_a[0] = vt[k].wa0; wr_a[1] = vt[k].wa1;
         wr_d[0] = vt[k].wd0; wr_d[1] = vt[k].wd1;
         iss_en = vt[k].ie; iss_addr = vt[k].ia; flush = vt[k].fl;
         #3;
         chk($sformatf("vec%0d rd_data[0]", k), rd_d[0], vt[k].ed0);
         chk($sformatf("vec%0d rd_data[1]", k), rd_d[1], vt[k].ed1);
         chk($sformatf("vec%0d rd_busy", k), rd_busy, vt[k].eb);
         model_comb($sformatf("vec%0d", k));
         clock_commit($sformatf("vec%0d", k));
         chk($sformatf("vec%0d table pend_cnt", k), pend_cnt, vt[k].ec);
      end

      // Mid-operation reset: reservations and storage drop without an edge.
      idle(); iss_en = 1; iss_addr = 2; wr_en = 2'b01; wr_a[0] = 8; wr_d[0] = 32'h55;
      step("mr0");
      idle(); iss_en = 1; iss_addr = 8; step("mr1");
      idle(); iss_en = 1; iss_addr = 30; step("mr2");
      idle(); rd_a[0] = 8; rd_a[1] = 29;
      chk("mr pend_cnt before", pend_cnt, 3);
      #1;
      chk("mr rd_data before", rd_d[0], 32'h55);
      chk("mr rd_busy before", rd_busy, 2'b01);
      reset = 1'b1;
      #1;
      chk("mr pend_cnt async", pend_cnt, 0);
      chk("mr rd_data[0] async", rd_d[0], 0);
      chk("mr rd_data[1] async", rd_d[1], 32'h7fc);
      chk("mr rd_busy async", rd_busy, 2'b00);
      m_reset();
      #3 reset = 1'b0;
      @(posedge clk); #1;
      step("post_reset");

      // Randomized traffic concentrated on a few registers to force hazards.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 2; i++) begin
            rd_a[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wr_a[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wr_d[i] = $urandom;
         end
         wr_en    = 2'($urandom_range(0, 3));
         iss_en   = ($urandom_range(0, 2) == 0);
         iss_addr = 5'($urandom_range(0, 7));
         flush    = ($urandom_range(0, 19) == 0);
         step($sformatf("rnd%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
